// File: rtl/regfile_mp_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_mp_pkg;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 32;
  localparam int RF_AW    = clog2(RF_DEPTH);

endpackage

// File: rtl/regfile_mp_if.sv
// Decode-stage bus of the multi-port register file, flattened per port.
interface regfile_mp_if #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
) ();

  // Strobe semantics: every *_en is a single-cycle request sampled on the rising
  // edge with its address/data; there is no back-pressure. rd_data/rd_busy update
  // one edge after an enabled read and otherwise hold.
  logic [NUM_RD-1:0]    rd_en;
  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rd_data;
  logic [NUM_RD-1:0]    rd_busy;
  logic [NUM_WR-1:0]    wr_en;
  logic [NUM_WR*AW-1:0] wr_addr;
  logic [NUM_WR*DW-1:0] wr_data;
  logic                 issue_en;
  logic [AW-1:0]        issue_addr;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
    output rd_data, rd_busy
  );

endinterface

// File: rtl/regfile_mp_wr_sel.sv
// Matches one address against all write ports; the highest-index enabled match wins.
module regfile_mp_wr_sel #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NUM_WR = 1
) (
  input  logic [AW-1:0]        addr_i,
  input  logic [NUM_WR-1:0]    wr_en_i,
  input  logic [NUM_WR*AW-1:0] wr_addr_i,
  input  logic [NUM_WR*DW-1:0] wr_data_i,
  output logic                 hit_o,
  output logic [DW-1:0]        data_o
);

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    // Ascending scan: a later (higher) port overwrites an earlier match.
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == addr_i)) begin
        hit_o  = 1'b1;
        data_o = wr_data_i[j*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-first read bypass and a per-register busy scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DW       = RF_DW,
  parameter int DEPTH    = RF_DEPTH,
  parameter int AW       = clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Post-update state; issue is applied after the write clears so it wins.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (bus.wr_en[j] && !is_zero(bus.wr_addr[j*AW +: AW])) begin
        mem_d[bus.wr_addr[j*AW +: AW]]  = bus.wr_data[j*DW +: DW];
        busy_d[bus.wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (bus.issue_en && !is_zero(bus.issue_addr)) begin
      busy_d[bus.issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;
    logic [DW-1:0] wdata;
    logic [DW-1:0] data_d;
    logic [DW-1:0] data_q;
    logic          rbusy_d;
    logic          rbusy_q;

    assign addr = bus.rd_addr[k*AW +: AW];

    regfile_mp_wr_sel #(
      .DW     (DW),
      .AW     (AW),
      .NUM_WR (NUM_WR)
    ) u_sel (
      .addr_i    (addr),
      .wr_en_i   (bus.wr_en),
      .wr_addr_i (bus.wr_addr),
      .wr_data_i (bus.wr_data),
      .hit_o     (hit),
      .data_o    (wdata)
    );

    // Register 0 must read zero even when a dropped write would bypass.
    always_comb begin
      data_d  = hit ? wdata : mem_q[addr];
      rbusy_d = busy_d[addr];
      if (is_zero(addr)) begin
        data_d  = '0;
        rbusy_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        rbusy_q <= 1'b0;
      end else if (bus.rd_en[k]) begin
        data_q  <= data_d;
        rbusy_q <= rbusy_d;
      end
    end

    assign bus.rd_data[k*DW +: DW] = data_q;
    assign bus.rd_busy[k]          = rbusy_q;
  end

endmodule
